// File: rtl/display_scan_controller_if.sv
// Bus between a host and the multiplexed 4-digit display scanner.
// Handshake: the host pulses carregar with valor stable for one clock; the
// load is taken only while ocupado is low, and pronto pulses for one clock
// when the new digits reach the display register.
interface display_scan_controller_if;
  logic [15:0] valor;
  logic        carregar;
  logic [3:0]  digito_bcd;
  logic [3:0]  anodo;
  logic        ocupado;
  logic        pronto;
  logic        estouro;
  logic [1:0]  fsm_state;  // debug view of the conversion FSM

  modport master (
    output valor, carregar,
    input  digito_bcd, anodo, ocupado, pronto, estouro, fsm_state
  );

  modport slave (
    input  valor, carregar,
    output digito_bcd, anodo, ocupado, pronto, estouro, fsm_state
  );
endinterface

// File: rtl/display_scan_controller.sv
// Binary-to-BCD (double dabble, one bit per clock) feeding a free-running
// 4-digit multiplexed scanner with optional leading-zero blanking.
module display_scan_controller #(
  parameter int CLK_DIV  = 4,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  display_scan_controller_if.slave  bus
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;          // pending digits once conversion ends
  logic [4:0]  iter_q, iter_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] disp_q, disp_d;        // digits currently being scanned
  logic        ovf_q, ovf_d;
  logic        pronto_q, pronto_d;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anodo_q, anodo_d;
  logic [3:0]    digito_q, digito_d;
  logic          presc_tc;

  // Add 3 to every nibble >= 5 before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Blank digits 3..1 while they and every higher digit are zero.
  function automatic logic [15:0] blank_lz(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    if (LZ_BLANK) begin
      if (b[15:12] == 4'd0) r[15:12] = 4'hF;
      if (b[15:8]  == 8'd0) r[11:8]  = 4'hF;
      if (b[15:4]  == 12'd0) r[7:4]  = 4'hF;
    end
    return r;
  endfunction

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    pronto_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.carregar) begin
          if (bus.valor > 16'd9999) begin
            bcd_d      = 16'hFFFF;
            ovf_pend_d = 1'b1;
            state_d    = UPDATE;
          end else begin
            bin_d      = bus.valor;
            bcd_d      = 16'h0000;
            iter_d     = 5'd16;
            ovf_pend_d = 1'b0;
            state_d    = CONVERT;
          end
        end
      end
      CONVERT: begin
        bcd_d  = {dabble_adjust(bcd_q) << 1} | {15'd0, bin_q[15]};
        bin_d  = {bin_q[14:0], 1'b0};
        iter_d = iter_q - 5'd1;
        if (iter_q == 5'd1) state_d = UPDATE;
      end
      UPDATE: begin
        disp_d   = blank_lz(bcd_q);
        ovf_d    = ovf_pend_q;
        pronto_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan index and the registered digit/anode pair that follow it.
  always_comb begin
    presc_tc = (presc_q == PW'(CLK_DIV - 1));
    idx_d    = presc_tc ? idx_q + 2'd1 : idx_q;
    anodo_d  = ~(4'b0001 << idx_d);
    digito_d = disp_d[{idx_d, 2'b00} +: 4];
  end

  // FSM and conversion registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= 16'hFFFF;
      ovf_q      <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      pronto_q   <= pronto_d;
    end
  end

  // Free-running prescaler and scan outputs, independent of the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      anodo_q  <= 4'b1110;
      digito_q <= 4'hF;
    end else begin
      presc_q  <= presc_tc ? '0 : presc_q + PW'(1);
      idx_q    <= idx_d;
      anodo_q  <= anodo_d;
      digito_q <= digito_d;
    end
  end

  assign bus.digito_bcd = digito_q;
  assign bus.anodo      = anodo_q;
  assign bus.ocupado    = (state_q != IDLE);
  assign bus.pronto     = pronto_q;
  assign bus.estouro    = ovf_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench: two instances (blanking on/off) loaded in lockstep.
module tb_display_scan_controller;

  localparam int CLK_DIV = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  display_scan_controller_if bus0 ();
  display_scan_controller_if bus1 ();

  display_scan_controller #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  display_scan_controller #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] valor;
    logic [15:0] exp_lz;
    logic [15:0] exp_nolz;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int anodo_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_anodo0"},  32'(bus0.anodo), 32'hE);
    check({tag, "_digito0"}, 32'(bus0.digito_bcd), 32'hF);
    check({tag, "_ocupado0"}, 32'(bus0.ocupado), 32'h0);
    check({tag, "_pronto0"}, 32'(bus0.pronto), 32'h0);
    check({tag, "_estouro0"}, 32'(bus0.estouro), 32'h0);
    check({tag, "_state0"},  32'(bus0.fsm_state), 32'h0);
    check({tag, "_anodo1"},  32'(bus1.anodo), 32'hE);
    check({tag, "_digito1"}, 32'(bus1.digito_bcd), 32'hF);
  endtask

  // Caller must be just after a negedge. Returns edges from load to pronto.
  task automatic load_and_wait(input logic [15:0] v, output int lat);
    bit found;
    bus0.valor = v; bus0.carregar = 1'b1;
    bus1.valor = v; bus1.carregar = 1'b1;
    @(posedge clock); #1;
    check("ocupado_after_load", 32'(bus0.ocupado), 32'h1);
    @(negedge clock);
    bus0.carregar = 1'b0;
    bus1.carregar = 1'b0;
    found = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(posedge clock); #1;
      if (bus0.pronto) begin
        found = 1'b1;
        lat = c;
      end
    end
    if (found) begin
      check("ocupado_at_pronto", 32'(bus0.ocupado), 32'h0);
      @(posedge clock); #1;
      check("pronto_one_cycle", 32'(bus0.pronto), 32'h0);
    end
  endtask

  // Align to the start of digit 0, then check one full scan period.
  task automatic scan_check(input logic [15:0] exp0, input logic [15:0] exp1, input string tag);
    logic [3:0] prev;
    bit synced;
    prev = bus0.anodo;
    synced = 1'b0;
    for (int c = 0; c < 20 && !synced; c++) begin
      @(posedge clock); #1;
      if (bus0.anodo == 4'b1110 && prev == 4'b0111) synced = 1'b1;
      else prev = bus0.anodo;
    end
    check({tag, "_scan_sync"}, 32'(synced), 32'h1);
    if (synced) begin
      for (int k = 0; k < 4 * CLK_DIV; k++) begin
        int d;
        logic [3:0] ea;
        if (k != 0) begin
          @(posedge clock); #1;
        end
        d = k / CLK_DIV;
        ea = ~(4'b0001 << d);
        check({tag, "_anodo"},   32'(bus0.anodo), 32'(ea));
        check({tag, "_digito0"}, 32'(bus0.digito_bcd), 32'(exp0[d*4 +: 4]));
        check({tag, "_digito1"}, 32'(bus1.digito_bcd), 32'(exp1[d*4 +: 4]));
      end
    end
  endtask

  initial begin
    int lat;
    int wraps;
    int pulses;
    logic [3:0] prev;
    logic [15:0] old_disp;

    vecs[0] = '{16'd1234,  16'h1234, 16'h1234, 1'b0, 17};
    vecs[1] = '{16'd7,     16'hFFF7, 16'h0007, 1'b0, 17};
    vecs[2] = '{16'd0,     16'hFFF0, 16'h0000, 1'b0, 17};
    vecs[3] = '{16'd10000, 16'hFFFF, 16'hFFFF, 1'b1, 1};
    vecs[4] = '{16'd9999,  16'h9999, 16'h9999, 1'b0, 17};
    vecs[5] = '{16'd65535, 16'hFFFF, 16'hFFFF, 1'b1, 1};
    vecs[6] = '{16'd1000,  16'h1000, 16'h1000, 1'b0, 17};
    vecs[7] = '{16'd50,    16'hFF50, 16'h0050, 1'b0, 17};
    vecs[8] = '{16'd9,     16'hFFF9, 16'h0009, 1'b0, 17};
    vecs[9] = '{16'd100,   16'hF100, 16'h0100, 1'b0, 17};

    bus0.valor = '0; bus0.carregar = 1'b0;
    bus1.valor = '0; bus1.carregar = 1'b0;

    // Reset
    #2 reset = 1'b0;
    #1 check_reset_state("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Table: first load lands on the first edge after reset release
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clock);
      load_and_wait(vecs[i].valor, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_estouro", i), 32'(bus0.estouro), 32'(vecs[i].exp_ovf));
      scan_check(vecs[i].exp_lz, vecs[i].exp_nolz, $sformatf("v%0d", i));
    end

    // Second load three cycles into a conversion is ignored
    old_disp = 16'hF100;
    @(negedge clock);
    bus0.valor = 16'd5678; bus0.carregar = 1'b1;
    bus1.valor = 16'd5678; bus1.carregar = 1'b1;
    @(posedge clock); #1;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clock);
      bus0.carregar = (c == 3);
      bus1.carregar = (c == 3);
      if (c == 3) begin
        bus0.valor = 16'd1111;
        bus1.valor = 16'd1111;
      end
      @(posedge clock); #1;
      if (bus0.pronto) lat = c;
      else if (anodo_idx(bus0.anodo) >= 0)
        check("old_digits_during_conv", 32'(bus0.digito_bcd),
              32'(old_disp[anodo_idx(bus0.anodo)*4 +: 4]));
    end
    @(negedge clock);
    bus0.carregar = 1'b0;
    bus1.carregar = 1'b0;
    check("ignored_load_latency", 32'(lat), 32'd17);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      if (bus0.pronto) pulses++;
    end
    check("ignored_load_no_pronto", 32'(pulses), 32'd0);
    scan_check(16'h5678, 16'h5678, "ignored_load");

    // Reset mid-conversion
    @(negedge clock);
    load_seq_start: begin
      bus0.valor = 16'd1234; bus0.carregar = 1'b1;
      bus1.valor = 16'd1234; bus1.carregar = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      bus0.carregar = 1'b0;
      bus1.carregar = 1'b0;
      repeat (7) @(posedge clock);
      #2 reset = 1'b0;
      #1 check_reset_state("midconv_reset");
      @(negedge clock);
      reset = 1'b1;
    end

    // Free run after reset: no pronto, blank display, three index wraps
    wraps = 0;
    pulses = 0;
    prev = bus0.anodo;
    for (int c = 1; c <= 4 * CLK_DIV * 3; c++) begin
      @(posedge clock); #1;
      check("freerun_onehot", 32'(anodo_idx(bus0.anodo) >= 0), 32'h1);
      check("freerun_blank", 32'(bus0.digito_bcd), 32'hF);
      if (bus0.pronto) pulses++;
      if (prev == 4'b0111 && bus0.anodo == 4'b1110) wraps++;
      prev = bus0.anodo;
    end
    check("freerun_wraps", 32'(wraps), 32'd3);
    check("abort_no_pronto", 32'(pulses), 32'd0);

    // Recovery load after the aborted conversion
    @(negedge clock);
    load_and_wait(16'd9999, lat);
    check("recover_latency", 32'(lat), 32'd17);
    check("recover_estouro", 32'(bus0.estouro), 32'd0);
    scan_check(16'h9999, 16'h9999, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter: CLK_DIV, default 4, clock cycles each digit stays selected (>= 2).
REQ-002 Parameter: LZ_BLANK, default 1, 1 = blank leading zeros (units digit never blanked).
REQ-003 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: valor  input  16  unsigned binary value to display.
REQ-006 Port: carregar  input  1  load strobe; sampled on a rising clock edge.
REQ-007 Port: digito_bcd  output  4  BCD code of the selected digit, fed to the existing 7-segment decoder; 4'hF = blank.
REQ-008 Port: anodo  output  4  active-low one-hot digit select; bit 0 = units.
REQ-009 Port: ocupado  output  1  high while a conversion is in progress.
REQ-010 Port: pronto  output  1  one-cycle pulse when new digits become visible.
REQ-011 Port: estouro  output  1  high while the displayed value is an overflow (valor > 9999).

Function
REQ-012 The FSM SHALL have states IDLE, CONVERT, UPDATE; the reset state is IDLE.
REQ-013 IDLE: carregar=1 with valor <= 9999 SHALL capture valor, clear a 16-bit BCD accumulator, load iteration count 16, go to CONVERT.
REQ-014 IDLE: carregar=1 with valor > 9999 SHALL set all four pending digits to 4'hF, set the pending overflow flag, and go directly to UPDATE.
REQ-015 CONVERT: each cycle SHALL add 3 to every BCD nibble >= 5, then shift {BCD, binary} left one bit; after the 16th shift go to UPDATE.
REQ-016 UPDATE: one cycle SHALL copy pending digits (with leading-zero blanking if LZ_BLANK=1) to the display register, copy the pending overflow flag to estouro, assert pronto, return to IDLE.
REQ-017 Latency: carregar at edge N SHALL give pronto high during cycle N+17 (normal) or N+1 (overflow).
REQ-018 ocupado SHALL be high in CONVERT and UPDATE, low in IDLE.
REQ-019 carregar asserted while ocupado=1 SHALL be ignored (no queueing).
REQ-020 Leading-zero blanking: digits 3..1 SHALL become 4'hF while they and all higher digits are zero; value 0 shows only units "0".
REQ-021 Display register SHALL change only in UPDATE; scanning shows the previous value during conversion.
REQ-022 Prescaler SHALL count 0..CLK_DIV-1 continuously; at terminal count the digit index SHALL advance 0->1->2->3->0 and the prescaler wraps to 0.
REQ-023 anodo SHALL equal ~(1 << index); digito_bcd SHALL equal display-register digit [index], both registered in the same cycle the index changes.
REQ-024 Scanning SHALL never stop, independent of FSM state.

Reset
REQ-025 On reset low, immediately: state IDLE, display register all 4'hF, index 0, prescaler 0, anodo 4'b1110, digito_bcd 4'hF, ocupado 0, pronto 0, estouro 0.
REQ-026 Reset asserted mid-conversion SHALL abort it; no pronto pulse and no display update afterwards.
REQ-027 First carregar SHALL be accepted on the first rising edge after reset release.

Verification
REQ-028 Reset, carregar with valor=1234 -> pronto 17 cycles later; scan yields digito_bcd 4,3,2,1 with anodo 1110,1101,1011,0111, each held CLK_DIV cycles.
REQ-029 valor=7, LZ_BLANK=1 -> digits units 7, others 4'hF; valor=0 -> units 0, others 4'hF; LZ_BLANK=0 with 7 -> 7,0,0,0.
REQ-030 valor=10000 -> pronto 1 cycle later, estouro=1, all digits 4'hF; then valor=9999 -> estouro=0, digits 9,9,9,9.
REQ-031 carregar 5678 then carregar 1111 three cycles later -> second ignored, display 5678 only; old digits shown until the pronto cycle.
REQ-032 Reset pulsed at cycle 8 of a conversion -> outputs at reset values, no pronto, display blank until next load.
REQ-033 Free-running 4*CLK_DIV*3 cycles -> index wraps exactly three times, anodo always one-hot low.
